sample_stats: RTL
=================

# sample_stats

Per-window statistics engine for the scope datapath. It consumes the ADC sample stream and computes minimum, maximum, mean and peak-to-peak over fixed power-of-two windows. Results are published only on a frame boundary, so the hex-digit overlay downstream never changes mid-frame. Its four 16-bit outputs drive the overlay's var1..var4 inputs directly.

## Interface
- SAMPLE_W, 10: sample width in bits; legal range 1..16.
- WIN_LOG2, 8: log2 of window length; window N = 2^WIN_LOG2 valid samples; legal range 1..16.

- clk  in  1  system clock (pixel clock domain, same as overlay)
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- sample  in  SAMPLE_W  unsigned ADC sample
- sample_valid  in  1  sample qualifier; one sample consumed per cycle when high
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- hold  in  1  freeze displayed values (front-panel hold)
- stat_min  out  16  window minimum, zero-extended (-> var1)
- stat_max  out  16  window maximum, zero-extended (-> var2)
- stat_mean  out  16  window mean, zero-extended (-> var3)
- stat_pp  out  16  max - min, zero-extended (-> var4)
- stats_updated  out  1  one-cycle pulse when outputs change

## Operation
- Accumulate stage: sample count cnt (WIN_LOG2 bits), sum acc (SAMPLE_W+WIN_LOG2 bits, cannot overflow), run_min, run_max. All of these advance only on sample_valid; gaps are allowed.
- Window start: the first valid sample (cnt==0) loads run_min and run_max with the sample, ignoring the old contents. The same sample loads acc = sample.
- Later valid samples: run_min = min(run_min, sample), run_max = max(run_max, sample), acc += sample, cnt++.
- Window completion: a valid sample with cnt==N-1 completes the window.
  - The pending snapshot loads min, max and mean = (acc+sample)>>WIN_LOG2 (truncating), with the current sample included.
  - pending is set and cnt wraps to 0.
- A newer completion overwrites an unpublished pending snapshot, so only the latest window is kept.
- Publish: on a frame_start cycle with hold=0 and data available, the outputs load, pending clears, and stats_updated pulses.
  - stat_pp = max - min, computed from the published pair.
- Simultaneous completion and frame_start (hold=0): the completing window bypasses pending and is published that edge; pending ends cleared.
- frame_start with hold=1: no publish; pending is retained and published at the first frame_start with hold=0.
- frame_start with nothing pending: outputs unchanged, no pulse.
- Reset (any time, including mid-window):
  - cnt, acc, run_min, run_max, pending and the snapshot all clear.
  - All outputs go to 0, stats_updated to 0.
  - A partial window is discarded.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Publish latency: outputs and stats_updated change on the clk edge where frame_start=1 is sampled. They are visible the following cycle and stable until the next publish.
- The completion-to-display latency is therefore bounded by one frame period.
- stats_updated is high exactly one cycle per publish, never two consecutive cycles.
- Full throughput: sample_valid may be high every cycle, with no stall and no backpressure.

## Structure
- Shared package scope_pkg: SAMPLE_W default, STAT_W=16, and a stats_t struct {min, max, mean} used for both the snapshot and the published registers.
- One natural sub-module: window_accum (cnt/acc/run_min/run_max, emits done pulse + stats_t). The top level holds the pending/publish logic and the pp subtraction.

## Test plan
All scenarios use WIN_LOG2=2 (N=4) and SAMPLE_W=10.
- Reset: assert reset_n=0 asynchronously mid-cycle -> all outputs 0 immediately, stats_updated=0; deassert, frame_start -> no pulse, outputs stay 0.
- Single window: samples 10,20,30,40, then frame_start -> min=10, max=40, mean=25, pp=30; stats_updated high one cycle.
- Overwrite plus gaps: windows 1,2,3,4 then 100,100,100,100 with idle cycles between samples, then frame_start -> min=100, max=100, mean=100, pp=0. A further frame_start -> no pulse, values unchanged.
- Bypass: samples 7,9,11 then sample 13 with sample_valid and frame_start in the same cycle -> min=7, max=13, mean=10, pp=6 published that edge; the next frame_start gives no pulse.
- Hold: complete window 0,0,1023,1023; frame_start with hold=1 -> outputs unchanged, no pulse. Drop hold, frame_start -> min=0, max=1023, mean=511, pp=1023.
- Mid-window reset: samples 50,60, reset pulse, then 1,1,1,1 and frame_start -> min=1, max=1, mean=1, pp=0 (pre-reset samples discarded).

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types for the scope statistics datapath.
// stats_t carries one window's min/max/mean at display width.
package scope_pkg;

  localparam int SAMPLE_W_DEFAULT = 10;
  localparam int STAT_W           = 16;

  typedef struct packed {
    logic [STAT_W-1:0] min;
    logic [STAT_W-1:0] max;
    logic [STAT_W-1:0] mean;
  } stats_t;

endpackage

// File: rtl/window_accum.sv
// Running min/max/sum over 2^WIN_LOG2 valid samples.
// done and stats are combinational so a completing window can publish same edge.
module window_accum
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic                done,
  output stats_t              stats
);

  localparam int ACC_W = SAMPLE_W + WIN_LOG2;

  logic [WIN_LOG2-1:0] r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [SAMPLE_W-1:0] r_min;
  logic [SAMPLE_W-1:0] r_max;

  logic                w_first;
  logic [SAMPLE_W-1:0] w_min;
  logic [SAMPLE_W-1:0] w_max;
  logic [ACC_W-1:0]    w_acc;
  logic [SAMPLE_W-1:0] w_mean;

  // First sample of a window replaces stale running values.
  always_comb begin
    w_first = (r_cnt == '0);
    w_min   = (w_first || sample < r_min) ? sample : r_min;
    w_max   = (w_first || sample > r_max) ? sample : r_max;
    w_acc   = (w_first ? '0 : r_acc) + ACC_W'(sample);
    w_mean  = w_acc[ACC_W-1:WIN_LOG2];
  end

  always_comb begin
    done       = sample_valid && (r_cnt == '1);
    stats.min  = STAT_W'(w_min);
    stats.max  = STAT_W'(w_max);
    stats.mean = STAT_W'(w_mean);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_min <= '0;
      r_max <= '0;
    end else if (sample_valid) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc;
      r_min <= w_min;
      r_max <= w_max;
    end
  end

endmodule

// File: rtl/sample_stats.sv
// Per-window sample statistics, published only on frame boundaries.
// Holds the latest completed window until a frame_start without hold.
module sample_stats
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int WIN_LOG2 = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic                frame_start,
  input  logic                hold,
  output logic [STAT_W-1:0]   stat_min,
  output logic [STAT_W-1:0]   stat_max,
  output logic [STAT_W-1:0]   stat_mean,
  output logic [STAT_W-1:0]   stat_pp,
  output logic                stats_updated
);

  logic   w_done;
  stats_t w_win;
  logic   w_pub;
  stats_t w_src;

  logic              r_pend;
  stats_t            r_snap;
  stats_t            r_pub;
  logic [STAT_W-1:0] r_pp;
  logic              r_upd;

  window_accum #(
    .SAMPLE_W(SAMPLE_W),
    .WIN_LOG2(WIN_LOG2)
  ) u_accum (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample      (sample),
    .sample_valid(sample_valid),
    .done        (w_done),
    .stats       (w_win)
  );

  // A window completing on the frame_start edge bypasses the snapshot.
  always_comb begin
    w_pub = frame_start && !hold && (w_done || r_pend);
    w_src = w_done ? w_win : r_snap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= 1'b0;
      r_snap <= '0;
      r_pub  <= '0;
      r_pp   <= '0;
      r_upd  <= 1'b0;
    end else if (w_pub) begin
      r_pub  <= w_src;
      r_pp   <= w_src.max - w_src.min;
      r_upd  <= 1'b1;
      r_pend <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (w_done) begin
        r_snap <= w_win;
        r_pend <= 1'b1;
      end
    end
  end

  assign stat_min      = r_pub.min;
  assign stat_max      = r_pub.max;
  assign stat_mean     = r_pub.mean;
  assign stat_pp       = r_pp;
  assign stats_updated = r_upd;

endmodule
